dmem_responder: RTL and testbench

- Data-memory responder for the pipelined RV32I core's load/store port. It accepts one request at a time over a valid/ready handshake and owns a word-organised RAM.
- It performs byte, halfword and word stores and loads, including sign or zero extension and alignment/range checking.
- After a configurable latency it returns the read data and an error flag over a second valid/ready handshake.
- It sits between the core's MEM stage and the data store.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 73 +++++++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RV32I load/store funct3 encodings
//   - responder FSM state type
//   - captured request record
//   - funct3 legality check (stores accept B/H/W, loads also BU/HU)
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit word RAM.
// Ports:
//   funct3     in  3   access size (bits 1:0) and unsigned-load flag (bit 2)
//   lane       in  2   byte offset within the word
//   wdata      in  32  right-justified store data
//   rword      in  32  raw word read from the RAM
//   byte_en    out 4   byte write enables for the store
//   wword      out 32  store data replicated onto every candidate lane
//   rdata_ext  out 32  load data extracted from the lane and extended
//   misaligned out 1   half access on an odd lane or word access on lane != 0
// Illegal size encodings (funct3[1:0] == 11) produce no byte enables; the
// caller flags them as errors.
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [15:0]        rlow;
    logic signed [7:0]  rbyte_s;
    logic signed [15:0] rhalf_s;

    // Shift the addressed lane down to bit 0; only 16 bits survive because
    // full-word loads bypass the shifter.
    assign rlow    = 16'(rword >> {lane, 3'b000});
    assign rbyte_s = rlow[7:0];
    assign rhalf_s = rlow;

    always_comb begin
        byte_en    = '0;
        wword      = wdata;
        rdata_ext  = rword;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wword   = {4{wdata[7:0]}};
                if (funct3[2]) begin
                    rdata_ext = {24'd0, rlow[7:0]};
                end else begin
                    rdata_ext = 32'(rbyte_s);
                end
            end
            2'b01: begin
                misaligned = lane[0];
                byte_en    = 4'b0011 << lane;
                wword      = {2{wdata[15:0]}};
                if (funct3[2]) begin
                    rdata_ext = {16'd0, rlow};
                end else begin
                    rdata_ext = 32'(rhalf_s);
                end
            end
            2'b10: begin
                misaligned = (lane != 2'b00);
                byte_en    = 4'b1111;
                wword      = wdata;
                rdata_ext  = rword;
            end
            default: begin
                byte_en = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I MEM stage.
// Accepts one load/store at a time, commits it LATENCY cycles after the
// accept edge against an internal word RAM, then holds the response until
// the core takes it.
// Parameters:
//   DEPTH_WORDS  RAM size in 32-bit words (power of two)
//   LATENCY      accept edge to resp_valid rising, 1..15
//   BASE_ADDR    byte address of word 0, aligned to DEPTH_WORDS*4
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  idle and out of reset
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   right-justified store data
//   req_funct3  in   RV32I load/store funct3
//   resp_valid  out  response present
//   resp_ready  in   core accepts response
//   resp_rdata  out  extended load data, 0 for stores and faults
//   resp_err    out  misaligned, out of range or illegal funct3
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_t      state;
    logic [3:0]  cnt;
    dmem_req_t   req_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] off;
    logic [AW-1:0] widx;
    logic [1:0]  lane;
    logic [31:0] rword;
    logic [3:0]  byte_en;
    logic [31:0] wword;
    logic [31:0] ld_data;
    logic        misaligned;
    logic        out_of_range;
    logic        err;
    logic        commit;
    logic        mem_we;

    assign req_ready = reset && (state == IDLE);

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign off          = req_q.addr - BASE_ADDR;
    assign out_of_range = {1'b0, off} >= SPAN;
    assign widx         = off[AW+1:2];
    assign lane         = off[1:0];
    assign rword        = mem[widx];

    mem_lane_align u_align (
        .funct3     (req_q.funct3),
        .lane       (lane),
        .wdata      (req_q.wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wword      (wword),
        .rdata_ext  (ld_data),
        .misaligned (misaligned)
    );

    assign err    = out_of_range || misaligned || !f3_legal(req_q.we, req_q.funct3);
    assign commit = (state == WAIT) && (cnt == 4'd0);
    // state drops to IDLE asynchronously in reset, so a store caught
    // mid-flight never reaches the RAM.
    assign mem_we = commit && req_q.we && !err;

    // Request capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
        end
    end

    // RAM write with byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[widx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // LATENCY==1 loads cnt=0, so WAIT commits on the next edge.
                        cnt   <= 4'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (err || req_q.we) ? 32'd0 : ld_data;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Three instances: [0] LATENCY=2 BASE=0 DEPTH=1024, [1] LATENCY=1
// BASE=0x1000 DEPTH=16, [2] LATENCY=3 BASE=0 DEPTH=16.
module tb_dmem_responder;

    localparam int LAT [3] = '{2, 1, 3};

    logic        clk = 1'b0;
    logic        reset       [3];
    logic        req_valid   [3];
    logic        req_ready   [3];
    logic        req_we      [3];
    logic [31:0] req_addr    [3];
    logic [31:0] req_wdata   [3];
    logic [2:0]  req_funct3  [3];
    logic        resp_valid  [3];
    logic        resp_ready  [3];
    logic [31:0] resp_rdata  [3];
    logic        resp_err    [3];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } sb_t;

    sb_t sbq[$];
    logic prev_v [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_l2 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_funct3(req_funct3[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) u_l1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_funct3(req_funct3[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_l3 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_funct3(req_funct3[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    // Monitor: latency check on resp_valid rising, data check on handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (resp_valid[i] && !prev_v[i]) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp inst=%0d rdata=%08h err=%0b required=none",
                             i, resp_rdata[i], resp_err[i]);
                end else if (cyc - sbq[0].acc != LAT[i]) begin
                    errors++;
                    $display("FAIL latency inst=%0d got=%0d required=%0d",
                             i, cyc - sbq[0].acc, LAT[i]);
                end
            end
            if (resp_valid[i] && resp_ready[i] && sbq.size() != 0) begin
                sb_t e;
                e = sbq.pop_front();
                checks++;
                if (e.inst != i || resp_rdata[i] !== e.rdata || resp_err[i] !== e.err) begin
                    errors++;
                    $display("FAIL resp inst=%0d rdata=%08h err=%0b required inst=%0d rdata=%08h err=%0b",
                             i, resp_rdata[i], resp_err[i], e.inst, e.rdata, e.err);
                end
            end
            prev_v[i] = resp_valid[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h required=%08h", name, got, exp);
        end
    endtask

    // Present one request on instance i and return just after the accept edge.
    task automatic do_req(input int i, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input bit exp_err, input bit push);
        int k;
        sb_t e;
        @(posedge clk); #1;
        req_we[i]     = we;
        req_addr[i]   = addr;
        req_wdata[i]  = wdata;
        req_funct3[i] = f3;
        req_valid[i]  = 1'b1;
        k = 0;
        while (!req_ready[i] && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!req_ready[i]) begin
            errors++;
            checks++;
            $display("FAIL req_ready_timeout inst=%0d got=0 required=1", i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_addr[i]  = 32'hFFFF_FFFF;  // later changes must not matter
        req_wdata[i] = 32'h0BAD_0BAD;
        if (push) begin
            e.inst = i; e.rdata = exp_rd; e.err = exp_err; e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic txn(input int i, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] exp_rd, input bit exp_err);
        do_req(i, we, addr, wdata, f3, exp_rd, exp_err, 1'b1);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; req_funct3[i] = '0;
            resp_ready[i] = 1'b1; prev_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  {31'd0, req_ready[0]},  32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("rst_resp_rdata", resp_rdata[0],          32'd0);
        chk("rst_resp_err",   {31'd0, resp_err[0]},   32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) reset[i] = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, req_ready[0]}, 32'd1);

        // Instance 0: LATENCY=2
        txn(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        0);  // SW
        txn(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0);  // LW
        txn(0, 0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 0);  // LB
        txn(0, 0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 0);  // LBU
        txn(0, 0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 0);  // LH
        txn(0, 0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 0);  // LHU
        txn(0, 1, 32'h11, 32'h55,       3'b000, 32'h0,        0);  // SB
        txn(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 0);  // LW
        txn(0, 0, 32'h11, 32'h0,        3'b000, 32'h00000055, 0);  // LB positive
        txn(0, 0, 32'h12, 32'h0,        3'b010, 32'h0,        1);  // LW misaligned
        txn(0, 1, 32'h11, 32'hAAAA,     3'b001, 32'h0,        1);  // SH misaligned
        txn(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 0);  // unchanged
        txn(0, 0, 32'h1000, 32'h0,      3'b010, 32'h0,        1);  // out of range
        txn(0, 0, 32'h10, 32'h0,        3'b011, 32'h0,        1);  // illegal load f3
        txn(0, 1, 32'h10, 32'h0,        3'b100, 32'h0,        1);  // illegal store f3
        txn(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 0);  // unchanged

        // Backpressure on instance 0
        resp_ready[0] = 1'b0;
        do_req(0, 0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 0, 1'b1);
        begin
            int k;
            k = 0;
            while (!resp_valid[0] && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, resp_valid[0]}, 32'd1);
            chk("bp_resp_rdata", resp_rdata[0],          32'hDEAD55EF);
            chk("bp_resp_err",   {31'd0, resp_err[0]},   32'd0);
            chk("bp_req_ready",  {31'd0, req_ready[0]},  32'd0);
        end
        @(posedge clk); #1;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_req_ready_after", {31'd0, req_ready[0]}, 32'd1);
        drain();

        // Instance 1: LATENCY=1, BASE=0x1000, 64-byte window
        txn(1, 1, 32'h1008, 32'hA5A50F0F, 3'b010, 32'h0,        0);
        txn(1, 0, 32'h1008, 32'h0,        3'b010, 32'hA5A50F0F, 0);
        txn(1, 0, 32'h100A, 32'h0,        3'b001, 32'hFFFFA5A5, 0);
        txn(1, 0, 32'h0FFC, 32'h0,        3'b010, 32'h0,        1);  // below base
        txn(1, 0, 32'h1040, 32'h0,        3'b010, 32'h0,        1);  // past end

        // Instance 2: LATENCY=3, reset mid-operation
        txn(2, 1, 32'h20, 32'h0, 3'b010, 32'h0, 0);
        do_req(2, 1, 32'h20, 32'h12345678, 3'b010, 32'h0, 0, 1'b0);
        @(posedge clk); #1;
        reset[2] = 1'b0;
        #1;
        chk("midrst_resp_valid", {31'd0, resp_valid[2]}, 32'd0);
        chk("midrst_req_ready",  {31'd0, req_ready[2]},  32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_hold_valid", {31'd0, resp_valid[2]}, 32'd0);
            chk("midrst_hold_ready", {31'd0, req_ready[2]},  32'd0);
        end
        @(posedge clk); #1;
        reset[2] = 1'b1;
        txn(2, 0, 32'h20, 32'h0, 3'b010, 32'h0, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
